// File: rtl/cache_ctrl_fsm.sv
// Cache control sequencer: hit/miss handling, line fill, dirty write-back and
// write-through for one processor access at a time.
module cache_ctrl_fsm #(
  parameter int WAIT_STATES  = 2,
  parameter int LINE_WORDS   = 4,
  parameter int WRITE_POLICY = 0,
  localparam int WW = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          PStrobe,
  input  logic          PRW,
  output logic          PReady,
  input  logic          Match,
  input  logic          Valid,
  input  logic          Dirty,
  output logic          Write,
  output logic          SetValid,
  output logic          SetDirty,
  output logic          ClrDirty,
  output logic          CacheDataSelect,
  output logic          PDataSelect,
  output logic          PDataOE,
  output logic          SysDataOE,
  output logic          SysStrobe,
  output logic          SysRW,
  output logic          WBAddrSel,
  output logic [WW-1:0] WordIdx,
  output logic          Busy
);

  // state   | meaning
  // IDLE    | waiting for PStrobe
  // LOOKUP  | tag compare result evaluated
  // WB      | write dirty victim line to system bus
  // FILL    | read line from system bus into cache
  // RESPOND | complete the access after a fill
  // WT      | single write-through beat
  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_WB, S_FILL, S_RESPOND, S_WT
  } state_t;

  localparam int CW = $clog2(WAIT_STATES + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_STATES);
  localparam logic [WW-1:0] LAST_WORD = WW'(LINE_WORDS - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] wait_q, wait_d;
  logic [WW-1:0] word_q, word_d;
  logic          rw_q, rw_d;

  logic beat_start, data_cyc, last_word, hit, victim_dirty;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
      word_q  <= '0;
      rw_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      word_q  <= word_d;
      rw_q    <= rw_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    wait_d          = '0;
    word_d          = word_q;
    rw_d            = rw_q;
    PReady          = 1'b0;
    Write           = 1'b0;
    SetValid        = 1'b0;
    SetDirty        = 1'b0;
    ClrDirty        = 1'b0;
    CacheDataSelect = 1'b0;
    PDataSelect     = 1'b0;
    PDataOE         = 1'b0;
    SysDataOE       = 1'b0;
    SysStrobe       = 1'b0;
    SysRW           = 1'b0;
    WBAddrSel       = 1'b0;
    WordIdx         = '0;
    Busy            = (state_q != S_IDLE);

    beat_start   = (wait_q == '0);
    data_cyc     = (wait_q == WAIT_LAST);
    last_word    = (word_q == LAST_WORD);
    hit          = Match & Valid;
    victim_dirty = (WRITE_POLICY == 1) && Valid && Dirty;

    // Beat states advance the wait counter, wrapping to 0 after the data cycle.
    if (state_q == S_WB || state_q == S_FILL || state_q == S_WT)
      wait_d = data_cyc ? '0 : wait_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        word_d = '0;
        if (PStrobe) begin
          rw_d    = PRW;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        word_d = '0;
        if (hit && rw_q) begin
          PReady  = 1'b1;
          PDataOE = 1'b1;
          state_d = S_IDLE;
        end else if (hit) begin
          Write           = 1'b1;
          CacheDataSelect = 1'b1;
          if (WRITE_POLICY == 1) begin
            SetDirty = 1'b1;
            PReady   = 1'b1;
            state_d  = S_IDLE;
          end else begin
            state_d = S_WT;
          end
        end else if (victim_dirty) begin
          state_d = S_WB;
        end else if (!rw_q && WRITE_POLICY == 0) begin
          state_d = S_WT;
        end else begin
          state_d = S_FILL;
        end
      end
      S_WB: begin
        SysStrobe = beat_start;
        SysDataOE = 1'b1;
        WBAddrSel = 1'b1;
        WordIdx   = word_q;
        if (data_cyc) begin
          word_d = word_q + 1'b1;
          if (last_word) begin
            ClrDirty = 1'b1;
            word_d   = '0;
            state_d  = S_FILL;
          end
        end
      end
      S_FILL: begin
        SysStrobe = beat_start;
        SysRW     = 1'b1;
        WordIdx   = word_q;
        if (data_cyc) begin
          Write  = 1'b1;
          word_d = word_q + 1'b1;
          if (last_word) begin
            SetValid = 1'b1;
            word_d   = '0;
            state_d  = S_RESPOND;
          end
        end
      end
      S_RESPOND: begin
        PReady = 1'b1;
        if (rw_q) begin
          PDataOE = 1'b1;
        end else begin
          Write           = 1'b1;
          CacheDataSelect = 1'b1;
          SetDirty        = 1'b1;
        end
        state_d = S_IDLE;
      end
      S_WT: begin
        SysStrobe = beat_start;
        SysDataOE = 1'b1;
        if (data_cyc) begin
          PReady  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: doc/cache_ctrl_fsm.md
Name: cache_ctrl_fsm

Overview:
- Parametrised next-generation cache control FSM for the processor/system-bus cache path.
- Sequences read and write hits and misses, multi-word line fill and dirty-line write-back, with selectable write-through or write-back/write-allocate policy.
- Controls the tag/data RAM write enable, the data-path muxes and output enables, and system-bus strobes.
- Wait-state counting and beat/word counting are internal.

Parameters:
WAIT_STATES, 2, system-bus wait cycles per beat; must be >=1; beat length = WAIT_STATES+1 cycles
LINE_WORDS, 4, words per cache line; power of two, >=1
WRITE_POLICY, 0, 0 = write-through, no write-allocate; 1 = write-back with write-allocate

Ports:
Clk  in  1  clock, rising edge
Reset  in  1  synchronous, active-high
PStrobe  in  1  processor request strobe; sampled only in IDLE
PRW  in  1  1 = read, 0 = write; captured with PStrobe
PReady  out  1  one-cycle pulse: processor access complete
Match  in  1  tag compare hit
Valid  in  1  line valid bit
Dirty  in  1  line dirty bit; ignored when WRITE_POLICY=0
Write  out  1  cache data RAM write enable
SetValid  out  1  set valid bit and write tag (last fill word)
SetDirty  out  1  set dirty bit
ClrDirty  out  1  clear dirty bit
CacheDataSelect  out  1  cache write data source: 1 = processor, 0 = system bus
PDataSelect  out  1  processor read data source: 1 = system bus, 0 = cache
PDataOE  out  1  drive processor data bus
SysDataOE  out  1  drive system data bus
SysStrobe  out  1  system-bus beat strobe
SysRW  out  1  system-bus direction: 1 = read, 0 = write
WBAddrSel  out  1  system address from victim tag (write-back)
WordIdx  out  max(1,clog2(LINE_WORDS))  current line word for fill/write-back
Busy  out  1  high in every state except IDLE

Behaviour:
- Reset state and outputs:
  - Reset high at a clock edge forces IDLE on the next cycle, whatever the current state; any bus transaction is abandoned.
  - Wait and word counters clear to 0; the captured RW clears to 0.
  - All outputs are 0 in IDLE.
- Output decode: outputs are decoded from state, counters, captured RW and, in LOOKUP only, Match/Valid/Dirty. No output depends on PStrobe.
- Beat definition:
  - A beat occupies WAIT_STATES+1 cycles.
  - SysStrobe is 1 in the first cycle only. SysRW, SysDataOE and WBAddrSel are held for the whole beat.
  - The last cycle of the beat (wait counter = WAIT_STATES) is the data cycle.
- States:
  - IDLE:
    - If PStrobe, capture PRW and go to LOOKUP; otherwise stay.
    - PStrobe in any other state is ignored.
  - LOOKUP (hit = Match & Valid):
    - Read hit: PReady=1, PDataOE=1, PDataSelect=0; go to IDLE.
    - Write hit, policy 1: Write=1, CacheDataSelect=1, SetDirty=1, PReady=1; go to IDLE.
    - Write hit, policy 0: Write=1, CacheDataSelect=1; go to WT.
    - Miss, policy 1 with Valid & Dirty: go to WB.
    - Read miss otherwise: go to FILL.
    - Write miss: policy 0 goes to WT (no allocate); policy 1 goes to FILL.
  - WB:
    - LINE_WORDS beats with SysRW=0, SysDataOE=1, WBAddrSel=1; WordIdx counts 0..LINE_WORDS-1.
    - Data cycle of the last beat: ClrDirty=1, then go to FILL.
  - FILL:
    - LINE_WORDS beats with SysRW=1.
    - Each data cycle: Write=1, CacheDataSelect=0.
    - Last data cycle also: SetValid=1; then go to RESPOND.
  - RESPOND (1 cycle):
    - Read: PReady=1, PDataOE=1, PDataSelect=0.
    - Write (allocate): Write=1, CacheDataSelect=1, SetDirty=1, PReady=1.
    - Then go to IDLE.
  - WT:
    - One beat with SysRW=0, SysDataOE=1.
    - Data cycle: PReady=1; then go to IDLE.
- Counters:
  - The wait counter clears at every beat start.
  - The word counter clears on entry to WB and to FILL, and increments on each data cycle.
  - For LINE_WORDS=1, WordIdx is a constant 0.
- Latency: PStrobe sampled in cycle 0.
  - Read hit: PReady in cycle 1.
  - Clean miss: PReady in cycle 2+LINE_WORDS*(WAIT_STATES+1).
  - Dirty miss: adds LINE_WORDS*(WAIT_STATES+1) cycles.
  - Write-through: PReady in cycle 1+(WAIT_STATES+1).
- Back-to-back: PStrobe in the cycle IDLE is re-entered starts a new access; there is no dead cycle beyond IDLE itself.

Test Plan:
- Defaults. PStrobe=1, PRW=1, Match=Valid=1 at cycle 0 -> cycle 1: PReady=PDataOE=1, Write=0; Busy=0 at cycle 2.
- Defaults, read miss (Valid=0) -> SysStrobe at cycles 2, 5, 8, 11; Write=1 at cycles 4, 7, 10, 13 with WordIdx 0..3; SetValid at cycle 13; PReady at cycle 14.
- Defaults, write hit -> Write=1 at cycle 1; SysStrobe=1, SysRW=0 at cycle 2; PReady at cycle 4; SetDirty never asserted.
- WRITE_POLICY=1, read miss with Valid=Dirty=1 -> 4 write beats with WBAddrSel=1 (cycles 2–13); ClrDirty at cycle 13; fill beats cycles 14–25; PReady at cycle 26.
- WRITE_POLICY=1, write miss, clean -> fill, then RESPOND with Write=CacheDataSelect=SetDirty=PReady=1 at cycle 14.
- Reset asserted during the FILL beat 2 wait cycle -> next cycle IDLE with all outputs 0; a later PStrobe restarts from LOOKUP with WordIdx=0.
